// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers and the accumulator state encoding.
package fxp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned acc_width(input int unsigned w_int, input int unsigned w_frac);
    return w_int + w_frac;
  endfunction

  // Largest / smallest signed value representable in w bits, held in a wide carrier.
  function automatic logic signed [127:0] sat_max(input int unsigned w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] sat_min(input int unsigned w);
    return -(128'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational saturating add/subtract of two W-bit signed operands.
module fxp_sat_add
  import fxp_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic signed [W:0] SMAX = (W+1)'(sat_max(W));
  localparam logic signed [W:0] SMIN = (W+1)'(sat_min(W));

  logic signed [W:0] ae;
  logic signed [W:0] be;
  logic signed [W:0] s;

  // One extra bit keeps a - b exact even when b is the most negative value.
  always_comb begin
    ae  = {a[W-1], a};
    be  = {b[W-1], b};
    s   = sub ? (ae - be) : (ae + be);
    ovf = 1'b0;
    if (s > SMAX) begin
      sum = SMAX[W-1:0];
      ovf = 1'b1;
    end else if (s < SMIN) begin
      sum = SMIN[W-1:0];
      ovf = 1'b1;
    end else begin
      sum = s[W-1:0];
    end
  end

endmodule

// File: rtl/fxp_width.sv
// Signed fixed-point resize: fraction align (optional round-half-up), then
// saturating integer narrowing with an overflow flag.
module fxp_width
  import fxp_pkg::*;
#(
  parameter int unsigned IN_INT   = 8,
  parameter int unsigned IN_FRAC  = 8,
  parameter int unsigned OUT_INT  = 8,
  parameter int unsigned OUT_FRAC = 8,
  parameter int unsigned ROUND    = 0
) (
  input  logic [IN_INT+IN_FRAC-1:0]   in_data,
  output logic [OUT_INT+OUT_FRAC-1:0] out_data,
  output logic                        ovf
);

  localparam int unsigned IW = IN_INT + IN_FRAC;
  localparam int unsigned OW = OUT_INT + OUT_FRAC;
  localparam int unsigned WF = max_u(IN_FRAC, OUT_FRAC);
  // Two spare integer bits: one for the rounding carry, one so OMAX/OMIN always fit.
  localparam int unsigned WW = max_u(IN_INT, OUT_INT) + 2 + WF;
  localparam int unsigned UP = WF - IN_FRAC;
  localparam int unsigned DN = WF - OUT_FRAC;
  localparam int unsigned DH = (DN > 0) ? DN - 1 : 0;

  localparam logic signed [WW-1:0] HALF =
    ((ROUND != 0) && (DN > 0)) ? ({{(WW-1){1'b0}}, 1'b1} << DH) : '0;
  localparam logic signed [WW-1:0] OMAX = WW'(sat_max(OW));
  localparam logic signed [WW-1:0] OMIN = WW'(sat_min(OW));

  logic signed [WW-1:0] x;
  logic signed [WW-1:0] y;

  always_comb begin
    x   = {{(WW-IW){in_data[IW-1]}}, in_data};
    x   = x <<< UP;
    y   = (x + HALF) >>> DN;
    ovf = 1'b0;
    if (y > OMAX) begin
      out_data = OW'(OMAX);
      ovf      = 1'b1;
    end else if (y < OMIN) begin
      out_data = OW'(OMIN);
      ovf      = 1'b1;
    end else begin
      out_data = y[OW-1:0];
    end
  end

endmodule

// File: rtl/fxp_accumulator.sv
// Framed fixed-point accumulator: sums cfg_len signed samples (add or subtract),
// then holds the resized sum and a sticky overflow flag until downstream takes it.
module fxp_accumulator
  import fxp_pkg::*;
#(
  parameter int unsigned IN_WIDTH_INT   = 8,
  parameter int unsigned IN_WIDTH_FRAC  = 8,
  parameter int unsigned ACC_WIDTH_INT  = 16,
  parameter int unsigned ACC_WIDTH_FRAC = 8,
  parameter int unsigned OUT_WIDTH_INT  = 8,
  parameter int unsigned OUT_WIDTH_FRAC = 8,
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned ROUND          = 1
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [LEN_WIDTH-1:0]                   cfg_len,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_WIDTH_INT+IN_WIDTH_FRAC-1:0]  in_data,
  input  logic                                   in_sub,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_WIDTH_INT+OUT_WIDTH_FRAC-1:0] out_data,
  output logic                                   out_overflow
);

  localparam int unsigned AW = acc_width(ACC_WIDTH_INT, ACC_WIDTH_FRAC);
  localparam int unsigned OW = OUT_WIDTH_INT + OUT_WIDTH_FRAC;

  acc_state_e           state;
  logic [AW-1:0]        acc;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 ovf_sticky;

  logic [AW-1:0]        sample_al;
  logic                 align_ovf;
  logic [AW-1:0]        add_a;
  logic [AW-1:0]        sum;
  logic                 add_ovf;
  logic [OW-1:0]        res;
  logic                 res_ovf;

  logic [LEN_WIDTH-1:0] cnt_inc;
  logic [LEN_WIDTH-1:0] len_eff;
  logic                 accept;
  logic                 last;
  logic                 frame_ovf;

  fxp_width #(
    .IN_INT  (IN_WIDTH_INT),
    .IN_FRAC (IN_WIDTH_FRAC),
    .OUT_INT (ACC_WIDTH_INT),
    .OUT_FRAC(ACC_WIDTH_FRAC),
    .ROUND   (0)
  ) u_align (
    .in_data (in_data),
    .out_data(sample_al),
    .ovf     (align_ovf)
  );

  fxp_sat_add #(
    .W(AW)
  ) u_add (
    .a  (add_a),
    .b  (sample_al),
    .sub(in_sub),
    .sum(sum),
    .ovf(add_ovf)
  );

  // Resize the post-add value so the result registers on the last-sample edge.
  fxp_width #(
    .IN_INT  (ACC_WIDTH_INT),
    .IN_FRAC (ACC_WIDTH_FRAC),
    .OUT_INT (OUT_WIDTH_INT),
    .OUT_FRAC(OUT_WIDTH_FRAC),
    .ROUND   (ROUND)
  ) u_resize (
    .in_data (sum),
    .out_data(res),
    .ovf     (res_ovf)
  );

  always_comb begin
    add_a     = (state == IDLE) ? '0 : acc;
    cnt_inc   = cnt + LEN_WIDTH'(1);
    len_eff   = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    accept    = in_valid && in_ready;
    frame_ovf = ovf_sticky | add_ovf | align_ovf;
    last      = (state == IDLE) ? (len_eff == LEN_WIDTH'(1)) : (cnt_inc == len_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      len_q        <= '0;
      ovf_sticky   <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc        <= sum;
            ovf_sticky <= frame_ovf;
            if (state == IDLE) begin
              cnt   <= LEN_WIDTH'(1);
              len_q <= len_eff;
            end else begin
              cnt <= cnt_inc;
            end
            if (last) begin
              state        <= HOLD;
              out_data     <= res;
              out_overflow <= frame_ovf | res_ovf;
              out_valid    <= 1'b1;
              in_ready     <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_accumulator.sv
// Self-checking bench for fxp_accumulator: directed frames plus randomized traffic
// compared every cycle against an integer-arithmetic frame model.
module tb_fxp_accumulator;

  localparam int AW  = 24;
  localparam int IFR = 8;
  localparam int AFR = 8;
  localparam int OFR = 8;
  localparam int OW  = 16;
  localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [7:0]  cfg_len;
  logic        in_valid, in_ready, in_sub;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_overflow;
  logic [15:0] out_data;

  logic        t_valid;
  logic [15:0] t_data;
  logic        r1_ready, r1_valid, r1_ovf, r0_ready, r0_valid, r0_ovf;
  logic [11:0] r1_data, r0_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  fxp_accumulator #(
    .IN_WIDTH_INT(8), .IN_WIDTH_FRAC(8), .ACC_WIDTH_INT(16), .ACC_WIDTH_FRAC(8),
    .OUT_WIDTH_INT(8), .OUT_WIDTH_FRAC(8), .LEN_WIDTH(8), .ROUND(1)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_overflow(out_overflow)
  );

  fxp_accumulator #(
    .IN_WIDTH_INT(8), .IN_WIDTH_FRAC(8), .ACC_WIDTH_INT(16), .ACC_WIDTH_FRAC(8),
    .OUT_WIDTH_INT(8), .OUT_WIDTH_FRAC(4), .LEN_WIDTH(8), .ROUND(1)
  ) dut_r1 (
    .clk(clk), .rstn(rstn), .cfg_len(8'd1), .in_valid(t_valid), .in_ready(r1_ready),
    .in_data(t_data), .in_sub(1'b0), .out_valid(r1_valid), .out_ready(1'b1),
    .out_data(r1_data), .out_overflow(r1_ovf)
  );

  fxp_accumulator #(
    .IN_WIDTH_INT(8), .IN_WIDTH_FRAC(8), .ACC_WIDTH_INT(16), .ACC_WIDTH_FRAC(8),
    .OUT_WIDTH_INT(8), .OUT_WIDTH_FRAC(4), .LEN_WIDTH(8), .ROUND(0)
  ) dut_r0 (
    .clk(clk), .rstn(rstn), .cfg_len(8'd1), .in_valid(t_valid), .in_ready(r0_ready),
    .in_data(t_data), .in_sub(1'b0), .out_valid(r0_valid), .out_ready(1'b1),
    .out_data(r0_data), .out_overflow(r0_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: sums in units of 2^-AFR, resize by arithmetic shift and range clamp.
  function automatic void resize(input longint s, input int d, input bit rnd, input int ow,
                                 output longint r, output bit ovf);
    longint omax, omin;
    omax = (64'sd1 <<< (ow - 1)) - 1;
    omin = -(64'sd1 <<< (ow - 1));
    if (d > 0 && rnd) s = s + (64'sd1 <<< (d - 1));
    r   = s >>> d;
    ovf = 0;
    if (r > omax) begin r = omax; ovf = 1; end
    else if (r < omin) begin r = omin; ovf = 1; end
  endfunction

  longint      m_sum;
  int          m_cnt = 0;
  int          m_len = 1;
  bit          m_ovf = 0;
  bit          m_hold = 0;
  bit          exp_ovf = 0;
  logic [15:0] exp_data = '0;

  always @(posedge clk) begin
    longint v, r;
    bit o;
    if (!rstn) begin
      m_hold = 0; m_cnt = 0; m_sum = 0; m_ovf = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      if (m_cnt == 0) begin
        m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
        m_sum = 0;
        m_ovf = 0;
      end
      v = longint'($signed(in_data)) <<< (AFR - IFR);
      m_sum = in_sub ? m_sum - v : m_sum + v;
      if (m_sum > ACC_MAX) begin m_sum = ACC_MAX; m_ovf = 1; end
      else if (m_sum < ACC_MIN) begin m_sum = ACC_MIN; m_ovf = 1; end
      m_cnt++;
      if (m_cnt == m_len) begin
        resize(m_sum, AFR - OFR, 1, OW, r, o);
        exp_data = r[15:0];
        exp_ovf  = m_ovf | o;
        m_hold   = 1;
        m_cnt    = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !m_hold);
      check("out_valid", out_valid, m_hold);
      if (m_hold) begin
        check("out_data", out_data, exp_data);
        check("out_overflow", out_overflow, exp_ovf);
      end
    end
  end

  task automatic send(input logic [7:0] len, input logic [15:0] d, input bit sub);
    bit ok = 0;
    cfg_len = len; in_data = d; in_sub = sub; in_valid = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_result(input string name, input logic [15:0] d, input bit o);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({name, "_latency"}, k, 0);
    check({name, "_data"}, out_data, d);
    check({name, "_ovf"}, out_overflow, o);
    @(posedge clk); #1;
  endtask

  logic [15:0] t6_in [3] = '{16'h0018, 16'hFFE8, 16'h0008};
  logic [11:0] t6_r1 [3] = '{12'h002, 12'hFFF, 12'h001};
  logic [11:0] t6_r0 [3] = '{12'h001, 12'hFFE, 12'h000};

  initial begin
    rstn = 0; cfg_len = 0; in_valid = 0; in_data = 0; in_sub = 0; out_ready = 1;
    t_valid = 0; t_data = 0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_overflow, 0);
    rstn = 1; chk_en = 1;

    send(3, 16'h0180, 0); send(3, 16'h0240, 0); send(3, 16'h0040, 0);
    wait_result("t1", 16'h0400, 0);

    send(2, 16'h0100, 0); send(2, 16'h0300, 1);
    wait_result("t2", 16'hFE00, 0);

    for (int i = 0; i < 255; i++) send(255, 16'h7FFF, 0);
    wait_result("t3_sat", 16'h7FFF, 1);
    send(1, 16'h0100, 0);
    wait_result("t3_clear", 16'h0100, 0);

    send(2, 16'h0100, 0);
    out_ready = 0;
    send(2, 16'h0200, 0);
    cfg_len = 1; in_data = 16'h0080; in_sub = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_data", out_data, 16'h0300);
      check("t4_hold_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    check("t4_idle_ready", in_ready, 1);
    check("t4_idle_valid", out_valid, 0);
    @(posedge clk); #1 in_valid = 0; out_ready = 1;
    wait_result("t4_next", 16'h0080, 0);

    send(4, 16'h0100, 0); send(4, 16'h0100, 0);
    rstn = 0;
    @(posedge clk); #1;
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 0);
    check("t5_out_ovf", out_overflow, 0);
    rstn = 1;
    send(1, 16'h0080, 0);
    wait_result("t5_new", 16'h0080, 0);

    for (int i = 0; i < 3; i++) begin
      t_data = t6_in[i]; t_valid = 1;
      @(posedge clk); #1 t_valid = 0;
      @(negedge clk);
      check("t6_r1_valid", r1_valid, 1);
      check("t6_r1_data", r1_data, t6_r1[i]);
      check("t6_r1_ovf", r1_ovf, 0);
      check("t6_r0_valid", r0_valid, 1);
      check("t6_r0_data", r0_data, t6_r0[i]);
      check("t6_r0_ovf", r0_ovf, 0);
      @(posedge clk); #1;
      check("t6_ready", r1_ready & r0_ready, 1);
    end

    for (int c = 0; c < 3000; c++) begin
      rstn      = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sub    = $urandom_range(0, 1);
      in_data   = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h0800) - 16'h0400);
      cfg_len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(7, 40)) : 8'($urandom_range(0, 6));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    rstn = 1; in_valid = 0; out_ready = 1;
    @(posedge clk); @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
